icache_param: RTL and testbench
===============================

// Module: icache_param
// PURPOSE
//   Parametrised direct-mapped, blocking, read-only instruction cache; next
//   generation of the fixed 16-set x 1-word icache. Sits between datapath fetch
//   (imemREN/imemaddr/ihit/imemload) and memory controller (iREN/iaddr/iwait/iload).
//   Multi-word lines, critical-word-first refill with wrap, flush, miss counter.
// PARAMETERS
//   SETS        16  number of lines, power of 2, >=2
//   BLOCK_WORDS 1   32-bit words per line, power of 2, 1..8
//   IDX_W  derived  $clog2(SETS); WSEL_W = $clog2(BLOCK_WORDS), 0 when BLOCK_WORDS=1
//   TAG_W  derived  32-2-WSEL_W-IDX_W (defaults give 26, matching the old icache)
// PORTS
//   CLK       in   1   clock, rising edge
//   RST       in   1   asynchronous, active-high reset
//   imemREN   in   1   fetch request
//   imemaddr  in   32  fetch byte address; bits [1:0] ignored
//   ihit      out  1   imemload valid this cycle
//   imemload  out  32  fetched instruction
//   flush     in   1   invalidate all lines (halt, self-modifying-code sync)
//   iREN      out  1   refill read request to memory controller
//   iaddr     out  32  refill word address, bits [1:0] = 0
//   iwait     in   1   high = iload not yet valid
//   iload     in   32  refill data
//   miss_cnt  out  32  saturating count of misses since reset
// BEHAVIOUR
//   Address split: tag=[31:32-TAG_W], idx, wsel=[WSEL_W+1:2], byte=[1:0].
//   Reset: all valid=0, state IDLE, ihit=0, iREN=0, iaddr=0, imemload=0, miss_cnt=0.
//   Tag/data array contents are undefined after reset; only valid is reset.
//   IDLE: ihit = imemREN & valid[idx] & tag match & !flush, combinational, 0-cycle.
//     imemload = data[idx][wsel] on hit, else 0.
//     On imemREN & miss & !flush: latch tag/idx/wsel into fill regs, clear valid[idx],
//     cnt<=0, miss_cnt+1 (holds at FFFF_FFFF), -> FILL.
//   FILL: iREN=1, iaddr={ftag,fidx,(fwsel+cnt) mod BLOCK_WORDS,2'b00}.
//     Order is requested word first, then wrapping (wsel 3 of 4: 3,0,1,2).
//     Each cycle with iwait=0: write iload to that word, cnt+1.
//     After word BLOCK_WORDS-1 is written: set valid[fidx], -> IDLE. ihit stays 0 in
//     FILL; the re-presented fetch hits the cycle after return to IDLE
//     (miss latency = sum of word waits + 1).
//     imemREN drop or imemaddr change during FILL: fill still completes; no abort.
//   flush: all valid<=0 in one cycle, either state; in FILL also -> IDLE, iREN=0 next
//     cycle, partial line stays invalid. flush in the same cycle as a miss: no fill,
//     no count. flush wins over the final fill write (line not validated).
//   RST mid-FILL: iREN drops immediately (async), all state as reset.
//   Line never valid while partially written; a hit cannot see stale words.
// STRUCTURE
//   Shared package (diaosi_types_pkg): icache_fsm_t {ICACHE_IDLE, ICACHE_FILL}, named
//   distinctly from existing IDLE literals. Also ICACHE_WORD_BYTES=4.
//   Parametrised line layout stays local: arrays valid[SETS], tag[SETS][TAG_W],
//   data[SETS][BLOCK_WORDS][32].
//   One sub-module: icache_line_store (arrays, async read, 1 word write port, valid
//   set/clear/flush-all), instantiated once; FSM, address gen, counter in top.
// TESTING (SETS=16, BLOCK_WORDS=4 unless noted; memory word = address ^ A5A5_0000)
//   1 Cold miss 0x0000_0104, iwait=0: iaddr 0x104,0x108,0x10C,0x100 on 4 cycles;
//     ihit on 5th with imemload 0xA5A5_0104; miss_cnt=1.
//   2 Then fetch 0x100,0x108,0x10C: ihit same cycle each, no iREN, miss_cnt stays 1.
//   3 Conflict 0x0000_0204 (same idx 0): refill, then 0x104 misses again;
//     miss_cnt=3.
//   4 flush asserted in 2nd fill cycle of 0x304: iREN 0 next cycle, 0x304 then
//     misses again with full 4-word refill.
//   5 iwait=1 for 3 cycles per word: iaddr held stable while iwait=1; order unchanged;
//     ihit 17 cycles after miss.
//   6 Default params: miss 0x0000_0040, one word; RST pulse mid-fill -> iREN 0 async,
//     refetch misses; miss_cnt forced to FFFF_FFFF stays there on next miss.

Source files
------------

// File: rtl/diaosi_types_pkg.sv
// Shared types for the datapath caches: icache FSM states and word geometry.
package diaosi_types_pkg;

   // Prefixed literals so they never collide with other IDLE states in the codebase.
   typedef enum logic {
      ICACHE_IDLE,
      ICACHE_FILL
   } icache_fsm_t;

   localparam int ICACHE_WORD_BYTES = 4;

endpackage

// File: rtl/icache_line_store.sv
// Direct-mapped line storage: valid bits, tags and multi-word data lines.
// Asynchronous read, one word write port, per-line valid set/clear, flush-all.
module icache_line_store
   import diaosi_types_pkg::*;
#(
   parameter int SETS        = 16,
   parameter int BLOCK_WORDS = 1,
   parameter int TAG_W       = 26,
   parameter int IDX_W       = $clog2(SETS),
   parameter int WS_W        = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [WS_W-1:0]  rd_wsel,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_data,
   input  logic             alloc,
   input  logic [IDX_W-1:0] alloc_idx,
   input  logic [TAG_W-1:0] alloc_tag,
   input  logic             word_we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WS_W-1:0]  wr_wsel,
   input  logic [31:0]      wr_data,
   input  logic             valid_set,
   input  logic             flush_all
);

   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tags [SETS];
   logic [31:0]      data [SETS][BLOCK_WORDS];

   // Valid bits: only state that is reset; flush beats any set or clear.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid <= '0;
      end else if (flush_all) begin
         valid <= '0;
      end else begin
         if (alloc)     valid[alloc_idx] <= 1'b0;
         if (valid_set) valid[wr_idx]    <= 1'b1;
      end
   end

   // Tag captured when a line is allocated; data written one word per refill beat.
   always_ff @(posedge CLK) begin
      if (alloc)   tags[alloc_idx]       <= alloc_tag;
      if (word_we) data[wr_idx][wr_wsel] <= wr_data;
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_data  = data[rd_idx][rd_wsel];

endmodule

// File: rtl/icache_param.sv
// Parametrised direct-mapped blocking read-only instruction cache with
// critical-word-first wrapping refill, flush and saturating miss counter.
module icache_param
   import diaosi_types_pkg::*;
#(
   parameter int SETS        = 16,
   parameter int BLOCK_WORDS = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        flush,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] miss_cnt
);

   localparam int BYTE_W = $clog2(ICACHE_WORD_BYTES);
   localparam int IDX_W  = $clog2(SETS);
   localparam int WSEL_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 0;
   localparam int WS_W   = (WSEL_W > 0) ? WSEL_W : 1;
   localparam int TAG_W  = 32 - BYTE_W - WSEL_W - IDX_W;
   localparam logic [WS_W-1:0] LAST_WORD = WS_W'(BLOCK_WORDS - 1);

   icache_fsm_t      state, next_state;
   logic [TAG_W-1:0] req_tag, ftag, rd_tag;
   logic [IDX_W-1:0] req_idx, fidx;
   logic [WS_W-1:0]  req_wsel, fwsel, cnt, fill_word;
   logic [31:0]      rd_data, miss_q;
   logic             rd_valid, line_hit, miss_start, xfer, last;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign req_tag  = imemaddr[31 -: TAG_W];
   assign req_idx  = imemaddr[BYTE_W + WSEL_W +: IDX_W];
   assign req_wsel = (WSEL_W > 0) ? imemaddr[BYTE_W +: WS_W] : '0;

   assign line_hit   = rd_valid && (rd_tag == req_tag);
   assign ihit       = (state == ICACHE_IDLE) && imemREN && line_hit && !flush;
   assign imemload   = ihit ? rd_data : 32'd0;
   assign miss_start = (state == ICACHE_IDLE) && imemREN && !line_hit && !flush;

   // Refill walks the line from the requested word, wrapping modulo the line size.
   assign fill_word = fwsel + cnt;
   assign xfer      = (state == ICACHE_FILL) && !iwait && !flush;
   assign last      = (cnt == LAST_WORD);

   icache_line_store #(
      .SETS        (SETS),
      .BLOCK_WORDS (BLOCK_WORDS),
      .TAG_W       (TAG_W),
      .IDX_W       (IDX_W),
      .WS_W        (WS_W)
   ) u_store (
      .CLK       (CLK),
      .RST       (RST),
      .rd_idx    (req_idx),
      .rd_wsel   (req_wsel),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .alloc     (miss_start),
      .alloc_idx (req_idx),
      .alloc_tag (req_tag),
      .word_we   (xfer),
      .wr_idx    (fidx),
      .wr_wsel   (fill_word),
      .wr_data   (iload),
      .valid_set (xfer && last),
      .flush_all (flush)
   );

   // Control state: FSM, beat counter and saturating miss counter.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= ICACHE_IDLE;
         cnt    <= '0;
         miss_q <= 32'd0;
      end else begin
         state <= next_state;
         if (miss_start) begin
            cnt    <= '0;
            miss_q <= sat_inc(miss_q);
         end else if (xfer) begin
            cnt <= cnt + WS_W'(1);
         end
      end
   end

   // Missing address held for the whole refill so fetch-side changes cannot disturb it.
   always_ff @(posedge CLK) begin
      if (miss_start) begin
         ftag  <= req_tag;
         fidx  <= req_idx;
         fwsel <= req_wsel;
      end
   end

   // Next state and refill request; flush abandons a partial line.
   always_comb begin
      next_state = state;
      iREN       = 1'b0;
      iaddr      = 32'd0;
      case (state)
         ICACHE_IDLE: begin
            if (miss_start) next_state = ICACHE_FILL;
         end
         ICACHE_FILL: begin
            iREN  = 1'b1;
            iaddr = (32'({ftag, fidx}) << (BYTE_W + WSEL_W)) | (32'(fill_word) << BYTE_W);
            if (flush)               next_state = ICACHE_IDLE;
            else if (!iwait && last) next_state = ICACHE_IDLE;
         end
         default: next_state = ICACHE_IDLE;
      endcase
   end

   assign miss_cnt = miss_q;

endmodule

// File: tb/tb_icache_param.sv
// Scoreboard bench: dut4 is SETS=16/BLOCK_WORDS=4, dut1 uses default parameters.
// Memory returns address ^ A5A5_0000 after a programmable number of wait cycles.
module tb_icache_param;

   logic        CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rst4, ren4, flush4, iwait4, ihit4, iren4;
   logic [31:0] addr4, load4, iaddr4, iload4, mcnt4;
   logic        rst1, ren1, flush1, iwait1, ihit1, iren1;
   logic [31:0] addr1, load1, iaddr1, iload1, mcnt1;

   assign iload4 = iaddr4 ^ 32'hA5A5_0000;
   assign iload1 = iaddr1 ^ 32'hA5A5_0000;

   icache_param #(.SETS(16), .BLOCK_WORDS(4)) dut4 (
      .CLK(CLK), .RST(rst4), .imemREN(ren4), .imemaddr(addr4), .ihit(ihit4),
      .imemload(load4), .flush(flush4), .iREN(iren4), .iaddr(iaddr4),
      .iwait(iwait4), .iload(iload4), .miss_cnt(mcnt4));

   icache_param dut1 (
      .CLK(CLK), .RST(rst1), .imemREN(ren1), .imemaddr(addr1), .ihit(ihit1),
      .imemload(load1), .flush(flush1), .iREN(iren1), .iaddr(iaddr1),
      .iwait(iwait1), .iload(iload1), .miss_cnt(mcnt1));

   int checks = 0;
   int fails  = 0;
   int wait4  = 0;
   int wait1  = 0;
   logic [31:0] req_q4[$], hit_q4[$], req_q1[$], hit_q1[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      fails++;
      $display("FAIL %s: unexpected output, value %h, nothing was required", name, act);
   endtask

   // Memory responders: wait N cycles per word, then present data with iwait low.
   initial begin
      int w = 0;
      iwait4 = 1'b0;
      forever begin
         @(posedge CLK); #1;
         if (iren4 === 1'b1) begin
            if (w >= wait4) begin iwait4 = 1'b0; w = 0; end
            else begin iwait4 = 1'b1; w++; end
         end else begin
            iwait4 = 1'b0; w = 0;
         end
      end
   end

   initial begin
      int w = 0;
      iwait1 = 1'b0;
      forever begin
         @(posedge CLK); #1;
         if (iren1 === 1'b1) begin
            if (w >= wait1) begin iwait1 = 1'b0; w = 0; end
            else begin iwait1 = 1'b1; w++; end
         end else begin
            iwait1 = 1'b0; w = 0;
         end
      end
   end

   // Monitors: pop and compare on every hit and every refill beat.
   initial begin
      forever begin
         @(negedge CLK);
         if (ihit4 === 1'b1) begin
            if (hit_q4.size() == 0) unexpected("dut4_ihit", load4);
            else chk("dut4_imemload", load4, hit_q4.pop_front());
         end
         if (iren4 === 1'b1) begin
            if (req_q4.size() == 0) unexpected("dut4_iREN", iaddr4);
            else if (iwait4 === 1'b1) chk("dut4_iaddr_stall", iaddr4, req_q4[0]);
            else chk("dut4_iaddr", iaddr4, req_q4.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         if (ihit1 === 1'b1) begin
            if (hit_q1.size() == 0) unexpected("dut1_ihit", load1);
            else chk("dut1_imemload", load1, hit_q1.pop_front());
         end
         if (iren1 === 1'b1) begin
            if (req_q1.size() == 0) unexpected("dut1_iREN", iaddr1);
            else if (iwait1 === 1'b1) chk("dut1_iaddr_stall", iaddr1, req_q1[0]);
            else chk("dut1_iaddr", iaddr1, req_q1.pop_front());
         end
      end
   end

   // Issue one fetch, queue the expected refill beats and hit data, check latency.
   task automatic fetch(input bit which, input logic [31:0] a, input bit miss,
                        input int exp_lat, input string name);
      int n;
      logic [1:0] ws;
      logic [1:0] w;
      ws = a[3:2];
      if (which == 1'b0) begin
         hit_q4.push_back(a ^ 32'hA5A5_0000);
         if (miss) begin
            for (int k = 0; k < 4; k++) begin
               w = ws + 2'(k);
               req_q4.push_back({a[31:4], w, 2'b00});
            end
         end
      end else begin
         hit_q1.push_back(a ^ 32'hA5A5_0000);
         if (miss) req_q1.push_back({a[31:2], 2'b00});
      end
      @(posedge CLK); #1;
      if (which == 1'b0) begin ren4 = 1'b1; addr4 = a; end
      else begin ren1 = 1'b1; addr1 = a; end
      n = 0;
      @(negedge CLK);
      while (((which ? ihit1 : ihit4) !== 1'b1) && n < 60) begin
         n++;
         @(negedge CLK);
      end
      chk({name, "_latency"}, 32'(n), 32'(exp_lat));
      @(posedge CLK); #1;
      if (which == 1'b0) ren4 = 1'b0;
      else ren1 = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst4 = 1'b1; ren4 = 1'b0; flush4 = 1'b0; addr4 = 32'd0;
      rst1 = 1'b1; ren1 = 1'b0; flush1 = 1'b0; addr1 = 32'd0;
      @(negedge CLK);
      chk("rst_ihit", {31'd0, ihit4}, 32'd0);
      chk("rst_iREN", {31'd0, iren4}, 32'd0);
      chk("rst_iaddr", iaddr4, 32'd0);
      chk("rst_imemload", load4, 32'd0);
      chk("rst_miss_cnt", mcnt4, 32'd0);
      chk("rst1_iREN", {31'd0, iren1}, 32'd0);
      chk("rst1_miss_cnt", mcnt1, 32'd0);
      @(posedge CLK); #1;
      rst4 = 1'b0; rst1 = 1'b0;

      // Cold miss, wrap order 104,108,10C,100, hit five cycles later.
      fetch(1'b0, 32'h0000_0104, 1'b1, 5, "t1_cold");
      chk("t1_miss_cnt", mcnt4, 32'd1);

      // Rest of the line hits with zero latency.
      fetch(1'b0, 32'h0000_0100, 1'b0, 0, "t2_hit100");
      fetch(1'b0, 32'h0000_0108, 1'b0, 0, "t2_hit108");
      fetch(1'b0, 32'h0000_010C, 1'b0, 0, "t2_hit10C");
      chk("t2_miss_cnt", mcnt4, 32'd1);

      // Conflict on index 0 evicts, original line misses again.
      fetch(1'b0, 32'h0000_0204, 1'b1, 5, "t3_conflict");
      fetch(1'b0, 32'h0000_0104, 1'b1, 5, "t3_refetch");
      chk("t3_miss_cnt", mcnt4, 32'd3);

      // Flush in the second fill beat abandons the line.
      req_q4.push_back(32'h0000_0304);
      req_q4.push_back(32'h0000_0308);
      @(posedge CLK); #1; ren4 = 1'b1; addr4 = 32'h0000_0304;
      @(posedge CLK); #1;
      @(posedge CLK); #1; flush4 = 1'b1; ren4 = 1'b0;
      @(posedge CLK); #1; flush4 = 1'b0;
      @(negedge CLK);
      chk("t4_iREN_after_flush", {31'd0, iren4}, 32'd0);
      chk("t4_miss_cnt_flush", mcnt4, 32'd4);
      // Flush in the same cycle as a miss: no fill, no count.
      @(posedge CLK); #1; ren4 = 1'b1; flush4 = 1'b1; addr4 = 32'h0000_0304;
      @(posedge CLK); #1; ren4 = 1'b0; flush4 = 1'b0;
      @(negedge CLK);
      chk("t4_iREN_flush_miss", {31'd0, iren4}, 32'd0);
      chk("t4_miss_cnt_flush_miss", mcnt4, 32'd4);
      fetch(1'b0, 32'h0000_0304, 1'b1, 5, "t4_refill");
      chk("t4_miss_cnt", mcnt4, 32'd5);

      // Three wait cycles per word: 4 words x 4 cycles + 1.
      wait4 = 3;
      fetch(1'b0, 32'h0000_001C, 1'b1, 17, "t5_wait");
      wait4 = 0;
      fetch(1'b0, 32'h0000_0014, 1'b0, 0, "t5_hit");
      chk("t5_miss_cnt", mcnt4, 32'd6);

      // Default parameters: reset pulse in the middle of a refill.
      wait1 = 3;
      req_q1.push_back(32'h0000_0040);
      @(posedge CLK); #1; ren1 = 1'b1; addr1 = 32'h0000_0040;
      @(posedge CLK); #1;
      chk("t6_iREN_fill", {31'd0, iren1}, 32'd1);
      #2 rst1 = 1'b1;
      #1;
      chk("t6_iREN_async_rst", {31'd0, iren1}, 32'd0);
      chk("t6_miss_cnt_rst", mcnt1, 32'd0);
      rst1 = 1'b0; ren1 = 1'b0; wait1 = 0;
      req_q1.delete();
      hit_q1.delete();
      fetch(1'b1, 32'h0000_0040, 1'b1, 2, "t6_refetch");
      chk("t6_miss_cnt", mcnt1, 32'd1);
      dut1.miss_q <= 32'hFFFF_FFFF;
      fetch(1'b1, 32'h0000_0080, 1'b1, 2, "t6_sat_miss");
      chk("t6_miss_cnt_sat", mcnt1, 32'hFFFF_FFFF);

      repeat (2) @(posedge CLK);
      chk("end_req_q4_empty", 32'(req_q4.size()), 32'd0);
      chk("end_hit_q4_empty", 32'(hit_q4.size()), 32'd0);
      chk("end_req_q1_empty", 32'(req_q1.size()), 32'd0);
      chk("end_hit_q1_empty", 32'(hit_q1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
